// File: rtl/tri_bbox_scanner.sv
// Raster front-end for point-in-triangle: latches a triangle, walks its signed
// bounding box in raster order, and streams the points the external tester flags.
module tri_bbox_scanner #(
    parameter int W     = 12,
    parameter int CNT_W = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [W-1:0]  ax,
    input  logic signed [W-1:0]  ay,
    input  logic signed [W-1:0]  bx,
    input  logic signed [W-1:0]  by,
    input  logic signed [W-1:0]  cx,
    input  logic signed [W-1:0]  cy,
    output logic                 busy,
    output logic                 done,
    output logic signed [W-1:0]  px,
    output logic signed [W-1:0]  py,
    output logic                 p_valid,
    input  logic                 in_tri,
    output logic                 hit_valid,
    input  logic                 hit_ready,
    output logic signed [W-1:0]  hit_x,
    output logic signed [W-1:0]  hit_y,
    output logic [CNT_W-1:0]     pix_count,
    output logic [CNT_W-1:0]     hit_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state;

    logic signed [W-1:0] va_x, va_y, vb_x, vb_y, vc_x, vc_y;
    logic signed [W-1:0] xmin, xmax, ymin, ymax;
    logic signed [W-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic                advance;
    logic                last_col;
    logic                last_pt;
    logic                load_hit;

    function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b,
                                                 input logic signed [W-1:0] c);
        logic signed [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b,
                                                 input logic signed [W-1:0] c);
        logic signed [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        box_xmin = min3(va_x, vb_x, vc_x);
        box_xmax = max3(va_x, vb_x, vc_x);
        box_ymin = min3(va_y, vb_y, vc_y);
        box_ymax = max3(va_y, vb_y, vc_y);
    end

    // A point may only retire when its hit (if any) has somewhere to go.
    always_comb begin
        advance  = !in_tri || !hit_valid || hit_ready;
        last_col = (px == xmax);
        last_pt  = last_col && (py == ymax);
        load_hit = (state == S_SCAN) && advance && in_tri;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            p_valid   <= 1'b0;
            hit_valid <= 1'b0;
            px        <= '0;
            py        <= '0;
            hit_x     <= '0;
            hit_y     <= '0;
            pix_count <= '0;
            hit_count <= '0;
            va_x      <= '0;
            va_y      <= '0;
            vb_x      <= '0;
            vb_y      <= '0;
            vc_x      <= '0;
            vc_y      <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymin      <= '0;
            ymax      <= '0;
        end else begin
            // A new load wins over a same-cycle drain, keeping the stream gapless.
            if (load_hit) begin
                hit_valid <= 1'b1;
                hit_x     <= px;
                hit_y     <= py;
            end else if (hit_ready) begin
                hit_valid <= 1'b0;
            end

            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        va_x      <= ax;
                        va_y      <= ay;
                        vb_x      <= bx;
                        vb_y      <= by;
                        vc_x      <= cx;
                        vc_y      <= cy;
                        pix_count <= '0;
                        hit_count <= '0;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    xmin    <= box_xmin;
                    xmax    <= box_xmax;
                    ymin    <= box_ymin;
                    ymax    <= box_ymax;
                    px      <= box_xmin;
                    py      <= box_ymin;
                    p_valid <= 1'b1;
                    state   <= S_SCAN;
                end

                S_SCAN: begin
                    if (advance) begin
                        pix_count <= pix_count + 1'b1;
                        if (in_tri) begin
                            hit_count <= hit_count + 1'b1;
                        end
                        if (last_pt) begin
                            p_valid <= 1'b0;
                            state   <= S_FLUSH;
                        end else if (last_col) begin
                            px <= xmin;
                            py <= py + 1'b1;
                        end else begin
                            px <= px + 1'b1;
                        end
                    end
                end

                S_FLUSH: begin
                    if (!hit_valid || hit_ready) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    p_valid <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
